// File: rtl/wb_arb_pkg.sv
// Shared types and Wishbone B4 cycle-type constants for the two-master arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/wb_arb_timeout.sv
// Stalled-beat watchdog: expire fires on the TIMEOUT-th consecutive stalled cycle.
module wb_arb_timeout #(
  parameter int TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset_n,
  input  logic stall,
  input  logic clear,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  assign expire = stall && (count == CW'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                      count <= '0;
    else if (clear || !stall || expire) count <= '0;
    else                               count <= count + 1'b1;
  end

endmodule

// File: rtl/wb_arbiter2.sv
// Round-robin Wishbone B4 arbiter, ibus (m0) and dbus (m1) onto one slave port.
// Optional stalled-slave watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter2
  import wb_arb_pkg::*;
#(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int SEL_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_adr,
  input  logic [DATA_W-1:0] m0_dat_w,
  output logic [DATA_W-1:0] m0_dat_r,
  input  logic [SEL_W-1:0]  m0_sel,
  input  logic              m0_cyc,
  input  logic              m0_stb,
  input  logic              m0_we,
  input  logic [2:0]        m0_cti,
  input  logic [1:0]        m0_bte,
  output logic              m0_ack,
  output logic              m0_err,
  input  logic [ADDR_W-1:0] m1_adr,
  input  logic [DATA_W-1:0] m1_dat_w,
  output logic [DATA_W-1:0] m1_dat_r,
  input  logic [SEL_W-1:0]  m1_sel,
  input  logic              m1_cyc,
  input  logic              m1_stb,
  input  logic              m1_we,
  input  logic [2:0]        m1_cti,
  input  logic [1:0]        m1_bte,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [ADDR_W-1:0] s_adr,
  output logic [DATA_W-1:0] s_dat_w,
  input  logic [DATA_W-1:0] s_dat_r,
  output logic [SEL_W-1:0]  s_sel,
  output logic              s_cyc,
  output logic              s_stb,
  output logic              s_we,
  output logic [2:0]        s_cti,
  output logic [1:0]        s_bte,
  input  logic              s_ack,
  input  logic              s_err
);

  arb_state_t state, state_nxt;
  logic       last, last_nxt;
  logic       expire;
  logic       g0, g1;

  assign g0 = (state == GNT0);
  assign g1 = (state == GNT1);

`ifdef WB_ARB_TIMEOUT_EN
  logic stall;
  // Built from master-side signals so the forced s_cyc drop cannot feed back.
  assign stall = ((g0 && m0_cyc && m0_stb) || (g1 && m1_cyc && m1_stb)) && !s_ack && !s_err;

  wb_arb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clock   (clock),
    .reset_n (reset_n),
    .stall   (stall),
    .clear   (state_nxt != state),
    .expire  (expire)
  );
`else
  localparam int unused_timeout = TIMEOUT;
  assign expire = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      IDLE: begin
        // On a tie, the master that did not own the bus last wins.
        if (m0_cyc && (!m1_cyc || last)) state_nxt = GNT0;
        else if (m1_cyc)                 state_nxt = GNT1;
      end
      GNT0: if (!m0_cyc || expire) begin
        last_nxt  = 1'b0;
        state_nxt = m1_cyc ? GNT1 : IDLE;
      end
      GNT1: if (!m1_cyc || expire) begin
        last_nxt  = 1'b1;
        state_nxt = m0_cyc ? GNT0 : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    s_adr   = '0;
    s_dat_w = '0;
    s_sel   = '0;
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_cti   = CTI_CLASSIC;
    s_bte   = BTE_LINEAR;
    if (g0) begin
      s_adr = m0_adr; s_dat_w = m0_dat_w; s_sel = m0_sel; s_cyc = m0_cyc;
      s_stb = m0_stb; s_we = m0_we; s_cti = m0_cti; s_bte = m0_bte;
    end else if (g1) begin
      s_adr = m1_adr; s_dat_w = m1_dat_w; s_sel = m1_sel; s_cyc = m1_cyc;
      s_stb = m1_stb; s_we = m1_we; s_cti = m1_cti; s_bte = m1_bte;
    end
    if (expire) begin
      s_cyc = 1'b0;
      s_stb = 1'b0;
    end
  end

  assign m0_ack   = g0 && s_ack;
  assign m0_err   = g0 && (s_err || expire);
  assign m0_dat_r = g0 ? s_dat_r : '0;
  assign m1_ack   = g1 && s_ack;
  assign m1_err   = g1 && (s_err || expire);
  assign m1_dat_r = g1 ? s_dat_r : '0;

endmodule
